cordic_core: RTL and testbench
==============================

CORDIC_CORE -- requirements
Module: cordic_core

Interface
REQ-001 SHALL have parameter ITERATIONS, default 14, legal range 8..14: number of CORDIC micro-rotations.
REQ-002 SHALL have parameter GUARD, default 2: extra internal LSB/MSB bits; internal datapath width is 16+GUARD.
REQ-003 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port compute, input, 1: request strobe, sampled only in IDLE.
REQ-006 SHALL have port func, input, 4: operation code, 0 = vectoring (atan2 + magnitude), 2 = rotation (sin/cos), all others unsupported.
REQ-007 SHALL have ports op1 and op2, input, 16 each: signed Q2.13 operands; op2 is used only by func 0.
REQ-008 SHALL have port busy, output, 1: high from the accept edge until done.
REQ-009 SHALL have port done, output, 1: single-cycle completion pulse.
REQ-010 SHALL have port result, output, 32: func 0 gives {magnitude, angle}; func 2 gives {cos, sin}; all fields signed Q2.13.
REQ-011 SHALL have port err, output, 1: valid with done, high for rejected requests.

Function
REQ-012 SHALL use FSM states IDLE, ITER, SCALE (only when the macro is compiled in) and FINISH.
REQ-013 IDLE with compute=1 at edge n SHALL capture func, op1 and op2, set busy, and enter ITER with i=0.
REQ-014 Rejection: an unsupported func, or func 2 with |op1| > 12868 (pi/2), SHALL skip ITER; done=1, err=1 and result=0 appear after edge n+1.
REQ-015 Rotation init: x=XINIT, y=0, z=op1.
- Each step: d=sign(z); x-=d*(y>>>i); y+=d*(x>>>i); z-=d*atan(i).
REQ-016 Vectoring init: x=op1, y=op2, z=0.
- If op1<0: x=-op1, y=-op2, z=+25736 (pi) when op2>=0, else -25736.
- Each step: d=-sign(y), same update equations as rotation.
REQ-017 SHALL execute exactly one iteration per ITER cycle, at edges n+1..n+ITERATIONS, then enter SCALE or FINISH.
REQ-018 FINISH SHALL register result, drive done=1 for one cycle, clear busy and return to IDLE.
- Latency: done follows edge n+ITERATIONS+1 without the macro, edge n+ITERATIONS+2 with it.
REQ-019 Output fields SHALL saturate to [-32768, 32767] when narrowing from 16+GUARD bits, never wrap.
REQ-020 result SHALL hold its value until the next done; err SHALL be 0 on every non-rejected done.
REQ-021 compute asserted while busy SHALL be ignored; no queuing.
- compute held high across FINISH starts a new operation from IDLE on the next edge.
REQ-022 Vectoring with op1=op2=0 SHALL return magnitude 0, angle 0, err=0.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, busy=0, done=0, err=0, result=0 and all datapath registers to 0, including mid-ITER.
REQ-024 After rst_n rises, the first compute SHALL be accepted on the next edge.

Configuration
REQ-025 Macro CORDIC_GAIN_COMP_EN defined:
- XINIT = 4975 (K=0.60725).
- The SCALE state multiplies vectoring magnitude by 4975 and shifts right by 13.
- Outputs are gain-corrected.
REQ-026 Macro CORDIC_GAIN_COMP_EN undefined:
- XINIT = 8192.
- No SCALE state and no multiplier.
- Outputs carry CORDIC gain of about 1.6468.

Structure
REQ-027 Package cordic_pkg SHALL hold:
- func codes FUNC_VEC=0 and FUNC_ROT=2;
- constants PI=25736, HALF_PI=12868, K_GAIN=4975, ONE=8192;
- the 14-entry Q2.13 atan(2^-i) table;
- the FSM state enum.
REQ-028 Sub-module cordic_atan_rom (index to angle, combinational) SHALL be the only child instance.

Verification (macro defined, ITERATIONS=14, tolerance +/-6 LSB)
REQ-029 func=2, op1=0 -> cos=8192, sin=0, err=0; done after edge n+16; busy high for 16 cycles.
REQ-030 func=0, op1=8192, op2=8192 -> angle=6434, magnitude=11585; func=0, op1=-8192, op2=0 -> angle=25736, magnitude=8192.
REQ-031 func=2, op1=13000, or func=5 -> done after edge n+1 with err=1 and result=0.
REQ-032 func=0, op1=-32768, op2=-32768 -> magnitude saturates to 32767, angle=-19302.
REQ-033 compute pulse at n+5 while busy -> ignored, exactly one done.
- rst_n low at n+7 -> busy, done and result are 0 without waiting for a clock edge.
REQ-034 Macro undefined, func=2, op1=0 -> cos=13490, sin=0; done after edge n+15.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants, atan(2^-i) table and FSM state type for the CORDIC core.
// The SCALE state exists only when CORDIC_GAIN_COMP_EN is defined.
package cordic_pkg;

  localparam logic [3:0] FUNC_VEC = 4'd0;
  localparam logic [3:0] FUNC_ROT = 4'd2;

  localparam int PI      = 25736;
  localparam int HALF_PI = 12868;
  localparam int K_GAIN  = 4975;
  localparam int ONE     = 8192;

  // atan(2^-i) in Q2.13, entry 0 at the LSB end
  localparam int ATAN_N = 14;
  localparam logic [ATAN_N-1:0][15:0] ATAN_TAB = {
    16'd1,   16'd2,   16'd4,    16'd8,    16'd16,   16'd32,   16'd64,
    16'd128, 16'd256, 16'd511,  16'd1019, 16'd2007, 16'd3798, 16'd6434
  };

`ifdef CORDIC_GAIN_COMP_EN
  typedef enum logic [1:0] {IDLE, ITER, SCALE, FINISH} state_t;
`else
  typedef enum logic [1:0] {IDLE, ITER, FINISH} state_t;
`endif

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational atan(2^-i) lookup, sign-extended to the datapath width.
module cordic_atan_rom
  import cordic_pkg::*;
#(
  parameter int W = 18
) (
  input  logic [3:0]          idx,
  output logic signed [W-1:0] angle
);

  always_comb begin
    angle = '0;
    if (idx < 4'(ATAN_N)) angle = W'(ATAN_TAB[idx]);
  end

endmodule

// File: rtl/cordic_core.sv
// Iterative CORDIC: vectoring (atan2 + magnitude) and rotation (sin/cos), one step per cycle.
// Define CORDIC_GAIN_COMP_EN to pre-scale rotation and post-scale vectoring magnitude by K.
module cordic_core
  import cordic_pkg::*;
#(
  parameter int ITERATIONS = 14,
  parameter int GUARD      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        compute,
  input  logic [3:0]  func,
  input  logic [15:0] op1,
  input  logic [15:0] op2,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        err
);

  localparam int W = 16 + GUARD;
`ifdef CORDIC_GAIN_COMP_EN
  localparam logic signed [W-1:0]  XINIT = W'(K_GAIN);
  localparam logic signed [W+12:0] KG    = (W+13)'(K_GAIN);
`else
  localparam logic signed [W-1:0]  XINIT = W'(ONE);
`endif
  localparam logic signed [W-1:0] PI_W = W'(PI);
  localparam logic signed [W-1:0] HP_W = W'(HALF_PI);
  localparam logic signed [W-1:0] SMAX = W'(32767);
  localparam logic signed [W-1:0] SMIN = W'(-32768);

  state_t state, nxt;
  logic signed [W-1:0] x, y, z, xs, ys, ang, op1_w, op2_w;
  logic [3:0] cnt;
  logic is_vec, rej, vzero, dpos, bad_req, last;

  function automatic logic [15:0] sat16(input logic signed [W-1:0] v);
    if (v > SMAX) return 16'h7fff;
    if (v < SMIN) return 16'h8000;
    return v[15:0];
  endfunction

  // rounding arithmetic shift keeps truncation bias out of the 14-step accumulation
  function automatic logic signed [W-1:0] shr(input logic signed [W-1:0] v, input logic [3:0] s);
    logic signed [W-1:0] r, t;
    r = (s == 4'd0) ? '0 : (W'(1) <<< (s - 4'd1));
    t = v + r;
    return t >>> s;
  endfunction

  cordic_atan_rom #(.W(W)) u_atan (.idx(cnt), .angle(ang));

  assign op1_w   = W'($signed(op1));
  assign op2_w   = W'($signed(op2));
  assign bad_req = !((func == FUNC_VEC) ||
                     ((func == FUNC_ROT) && (op1_w <= HP_W) && (op1_w >= -HP_W)));
  assign last    = (cnt == 4'(ITERATIONS - 1));
  assign xs      = shr(y, cnt);
  assign ys      = shr(x, cnt);
  assign dpos    = is_vec ? y[W-1] : ~z[W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (compute) nxt = bad_req ? FINISH : ITER;
      ITER: if (last) begin
`ifdef CORDIC_GAIN_COMP_EN
        nxt = SCALE;
`else
        nxt = FINISH;
`endif
      end
`ifdef CORDIC_GAIN_COMP_EN
      SCALE:  nxt = FINISH;
`endif
      FINISH: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0; y <= '0; z <= '0; cnt <= '0;
      is_vec <= 1'b0; rej <= 1'b0; vzero <= 1'b0;
      busy <= 1'b0; done <= 1'b0; err <= 1'b0; result <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (compute) begin
          busy   <= 1'b1;
          cnt    <= '0;
          rej    <= bad_req;
          is_vec <= (func == FUNC_VEC);
          vzero  <= (op1 == '0) && (op2 == '0);
          if (func == FUNC_VEC) begin
            // fold left half-plane into the right so the rotations converge
            if (op1[15]) begin
              x <= -op1_w;
              y <= -op2_w;
              z <= op2[15] ? -PI_W : PI_W;
            end else begin
              x <= op1_w;
              y <= op2_w;
              z <= '0;
            end
          end else begin
            x <= XINIT;
            y <= '0;
            z <= op1_w;
          end
        end
        ITER: begin
          cnt <= cnt + 4'd1;
          if (dpos) begin
            x <= x - xs; y <= y + ys; z <= z - ang;
          end else begin
            x <= x + xs; y <= y - ys; z <= z + ang;
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        SCALE: if (is_vec) x <= W'((x * KG) >>> 13);
`endif
        FINISH: begin
          busy <= 1'b0;
          done <= 1'b1;
          err  <= rej;
          if (rej)         result <= '0;
          else if (is_vec) result <= {sat16(x), vzero ? 16'h0000 : sat16(z)};
          else             result <= {sat16(x), sat16(y)};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_core.sv
// Scoreboard bench for cordic_core: expected results from a real-math model, compared on done.
module tb_cordic_core;

  localparam int ITER = 14;
  localparam int TOL  = 6;
`ifdef CORDIC_GAIN_COMP_EN
  localparam real XIN = 4975.0;
  localparam real MSC = 4975.0 / 8192.0;
  localparam int  LAT = ITER + 2;
`else
  localparam real XIN = 8192.0;
  localparam real MSC = 1.0;
  localparam int  LAT = ITER + 1;
`endif

  logic clk = 1'b0, rst_n = 1'b0, compute = 1'b0;
  logic [3:0] func = '0;
  logic [15:0] op1 = '0, op2 = '0;
  logic busy, done, err;
  logic [31:0] result;

  cordic_core #(.ITERATIONS(ITER), .GUARD(2)) dut (
    .clk(clk), .rst_n(rst_n), .compute(compute), .func(func), .op1(op1), .op2(op2),
    .busy(busy), .done(done), .result(result), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  rej;
    int    hi;
    int    lo;
    int    lat;
    int    acc;
    string name;
  } exp_t;

  exp_t sb[$];
  int checks = 0, errors = 0, cyc = 0, ndone = 0;
  real an = 1.0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sat(input int v);
    return (v > 32767) ? 32767 : ((v < -32768) ? -32768 : v);
  endfunction

  function automatic exp_t model(input string nm, input int f, input int a, input int b);
    exp_t e;
    real t;
    e.name = nm; e.acc = 0; e.rej = 1'b0; e.lat = LAT; e.hi = 0; e.lo = 0;
    if (f == 2 && a <= 12868 && a >= -12868) begin
      t = a / 8192.0;
      e.hi = sat(int'(XIN * an * $cos(t)));
      e.lo = sat(int'(XIN * an * $sin(t)));
    end else if (f == 0) begin
      if (a != 0 || b != 0) begin
        e.hi = sat(int'(MSC * an * $sqrt(real'(a) * a + real'(b) * b)));
        e.lo = sat(int'($atan2(real'(b), real'(a)) * 8192.0));
      end
    end else begin
      e.rej = 1'b1;
      e.lat = 1;
    end
    return e;
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    int dh, dl;
    if (rst_n && done) begin
      ndone++;
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done result=%h err=%b", result, err);
      end else begin
        e = sb.pop_front();
        dh = int'($signed(result[31:16])) - e.hi;
        dl = int'($signed(result[15:0])) - e.lo;
        checks++;
        if (cyc - e.acc !== e.lat) begin
          errors++; $display("FAIL %s latency got=%0d want=%0d", e.name, cyc - e.acc, e.lat);
        end
        checks++;
        if (err !== e.rej) begin
          errors++; $display("FAIL %s err got=%b want=%b", e.name, err, e.rej);
        end
        checks++;
        if (dh > TOL || dh < -TOL || (e.rej && dh != 0)) begin
          errors++; $display("FAIL %s hi got=%0d want=%0d", e.name, $signed(result[31:16]), e.hi);
        end
        checks++;
        if (dl > TOL || dl < -TOL || (e.rej && dl != 0)) begin
          errors++; $display("FAIL %s lo got=%0d want=%0d", e.name, $signed(result[15:0]), e.lo);
        end
      end
    end
  end

  task automatic issue(input string nm, input int f, input int a, input int b);
    exp_t e;
    @(negedge clk);
    compute = 1'b1; func = 4'(f); op1 = 16'(a); op2 = 16'(b);
    @(posedge clk); #1;
    compute = 1'b0;
    e = model(nm, f, a, b);
    e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic drain(output bit ok);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (sb.size() == 0);
    if (!ok) sb.delete();
    @(negedge clk);
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags got=%b want=000", {busy, done, err});
    end
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL reset_result got=%h want=0", result);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rotation();
    int rv[$] = '{6434, -6434, 12868, -12868, 3000, -10000};
    int nb = 0, k = 0;
    bit ok;
    issue("rot_0", 2, 0, 0);
    while (!done && k < 100) begin
      @(negedge clk);
      if (busy) nb++;
      k++;
    end
    checks++;
    if (nb != LAT) begin
      errors++; $display("FAIL rot_busy_cycles got=%0d want=%0d", nb, LAT);
    end
    drain(ok);
    foreach (rv[i]) begin
      issue($sformatf("rot_%0d", rv[i]), 2, rv[i], 0);
      drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rot_timeout got=pending want=done"); end
    end
  endtask

  task automatic test_vectoring();
    int av[$] = '{8192, -8192, 5000, -3000, 0, 0, 0, 7000};
    int bv[$] = '{8192, 0, -7000, 4000, 8192, -8192, 0, 1};
    bit ok;
    foreach (av[i]) begin
      issue($sformatf("vec_%0d_%0d", av[i], bv[i]), 0, av[i], bv[i]);
      drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL vec_timeout got=pending want=done"); end
    end
  endtask

  task automatic test_reject();
    int fv[$] = '{2, 2, 5, 1, 15, 2};
    int av[$] = '{13000, -13000, 0, 100, 8192, 12869};
    bit ok;
    foreach (fv[i]) begin
      issue($sformatf("rej_f%0d_%0d", fv[i], av[i]), fv[i], av[i], 77);
      drain(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rej_timeout got=pending want=done"); end
    end
  endtask

  task automatic test_saturation();
    bit ok;
    issue("sat_neg", 0, -32768, -32768);
    drain(ok);
    issue("sat_pos", 0, 32767, 32767);
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL sat_timeout got=pending want=done"); end
  endtask

  task automatic test_ignore_busy();
    int n0;
    bit ok;
    n0 = ndone;
    issue("ign_main", 0, 8192, 8192);
    repeat (4) @(posedge clk);
    @(negedge clk);
    compute = 1'b1; func = 4'd2; op1 = 16'd1000; op2 = 16'd0;
    @(posedge clk); #1;
    compute = 1'b0;
    drain(ok);
    repeat (LAT + 4) @(negedge clk);
    checks++;
    if (ndone - n0 != 1) begin
      errors++; $display("FAIL ign_done_count got=%0d want=1", ndone - n0);
    end
  endtask

  task automatic test_reset_mid();
    exp_t e;
    bit ok;
    issue("rst_mid", 2, 6434, 0);
    repeat (7) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, err} !== 3'b000) begin
      errors++; $display("FAIL rst_mid_flags got=%b want=000", {busy, done, err});
    end
    checks++;
    if (result !== 32'h0) begin
      errors++; $display("FAIL rst_mid_result got=%h want=0", result);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    compute = 1'b1; func = 4'd2; op1 = 16'd0; op2 = 16'd0;
    @(posedge clk); #1;
    compute = 1'b0;
    e = model("rst_after", 2, 0, 0);
    e.acc = cyc;
    sb.push_back(e);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL rst_first_accept busy got=%b want=1", busy);
    end
    drain(ok);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int k = 0;
    bit ok;
    @(negedge clk);
    compute = 1'b1; func = 4'd0; op1 = 16'(-8192); op2 = 16'd0;
    @(posedge clk); #1;
    e = model("b2b_first", 0, -8192, 0);
    e.acc = cyc;
    sb.push_back(e);
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (!done) begin errors++; $display("FAIL b2b_first_done got=0 want=1"); end
    func = 4'd2; op1 = 16'(-6434);
    @(posedge clk); #1;
    compute = 1'b0;
    e = model("b2b_second", 2, -6434, 0);
    e.acc = cyc;
    sb.push_back(e);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL b2b_second_accept busy got=%b want=1", busy);
    end
    drain(ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL b2b_timeout got=pending want=done"); end
  endtask

  initial begin
    for (int i = 0; i < ITER; i++) an = an * $sqrt(1.0 + 2.0 ** (-2.0 * i));
    test_reset();
    test_rotation();
    test_vectoring();
    test_reject();
    test_saturation();
    test_ignore_busy();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
